adder_segmented_pipe: RTL and testbench
=======================================

ADDER_SEGMENTED_PIPE -- requirements
Module: adder_segmented_pipe

Interface
REQ-001 Parameter WIDTH, default 64, operand/result width in bits.
REQ-002 Parameter SEG, default 32, segment width in bits; WIDTH SHALL be an integer multiple of SEG, with NSEG = WIDTH/SEG >= 1.
REQ-003 Port CLK  input  1  single clock; all state SHALL update on rising edge.
REQ-004 Port RST  input  1  reset, synchronous, active-high.
REQ-005 Port ce  input  1  clock enable; 0 freezes every pipeline register, including valid bits.
REQ-006 Port in_valid  input  1  operands valid this cycle.
REQ-007 Port a, b  input  WIDTH  unsigned/two's-complement operands.
REQ-008 Port cin  input  1  carry-in.
REQ-009 Port sub  input  1  0 = add, 1 = subtract.
REQ-010 Port out_valid  output  1  result valid.
REQ-011 Port sum  output  WIDTH  result.
REQ-012 Port cout  output  1  carry-out of bit WIDTH-1.
REQ-013 Port ovf  output  1  signed overflow.

Function
REQ-014 The block SHALL compute {cout,sum} = a + b + cin when sub=0, and a + ~b + ~cin (that is a - b - cin) when sub=1.
REQ-015 ovf SHALL be 1 when the signs of a and the effective b operand (b or ~b) are equal and sum[WIDTH-1] differs from them; otherwise 0.
REQ-016 Stage k (k = 0..NSEG-1) SHALL add segment k of its operands plus the carry registered by stage k-1 (stage 0 uses the effective carry-in).
REQ-017 Stage k SHALL register its segment result, its carry, and the still-unused upper operand segments.
REQ-018 Lower result segments SHALL be delayed so that all segments of one operation exit together.
REQ-019 Latency SHALL be exactly NSEG enabled cycles from the in_valid sample to out_valid, sum, cout and ovf.
REQ-020 Throughput SHALL be one operation per enabled cycle; back-to-back operations SHALL NOT interfere.
REQ-021 The valid bit SHALL travel with its data through a shift register of depth NSEG.
REQ-022 Data registers MAY load regardless of in_valid; sum, cout and ovf are meaningful only while out_valid=1.
REQ-023 While ce=0, all outputs SHALL hold; on the first cycle ce returns to 1, the pipeline SHALL resume with no loss or duplication.
REQ-024 NSEG=1 SHALL degenerate to a single registered adder with latency 1.
REQ-025 All-ones + 1 SHALL produce sum=0 and cout=1, with the carry propagating across every segment boundary.
REQ-026 If RST and ce are both 1, RST SHALL take priority.

Reset
REQ-027 When RST=1 at a rising edge, all valid bits, out_valid, sum, cout, ovf and all internal carries and data registers SHALL become 0.
REQ-028 Operations in flight at reset SHALL be discarded; none SHALL emerge afterwards.
REQ-029 The first out_valid after reset SHALL occur NSEG cycles after the first in_valid=1 sampled with RST=0 and ce=1.

Structure
REQ-030 Package adder_pkg SHALL hold the WIDTH/SEG defaults and an NSEG derivation function.
REQ-031 Sub-module adder_seg_stage (SEG-bit add with carry in/out, registered, with ce and RST) SHALL be instantiated NSEG times in a generate loop.
REQ-032 Skew/deskew registers and the valid chain SHALL reside in the top level.

Verification
REQ-033 Defaults, sub=0, cin=0, a=64'hFFFF_FFFF_FFFF_FFFF, b=1 -> two cycles later out_valid=1, sum=0, cout=1, ovf=0.
REQ-034 sub=0, a=64'h7FFF_FFFF_FFFF_FFFF, b=1 -> sum=64'h8000_0000_0000_0000, ovf=1, cout=0.
REQ-035 sub=1, cin=0, a=5, b=7 -> sum=64'hFFFF_FFFF_FFFF_FFFE, cout=0; sub=1, cin=1, a=10, b=3 -> sum=6, cout=1.
REQ-036 Streaming with ce held at 1 and in_valid=1 for 8 cycles (a=i<<32 | 32'hFFFF_FFFF, b=1) -> 8 consecutive out_valid pulses, sum=(i+1)<<32, in order.
REQ-037 Toggle ce=0 for 3 cycles mid-stream, then assert RST for 1 cycle with 2 operations in flight -> outputs frozen during ce=0; after RST, out_valid=0 until a new operation completes.
REQ-038 WIDTH=96, SEG=32, random operands vs reference model -> latency 3, zero mismatches over 10k vectors.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared configuration for the segmented pipelined adder.
// Holds the default operand/segment widths and the segment-count derivation
// used to size the pipeline.
package adder_pkg;

    localparam int unsigned ADDER_WIDTH = 64;
    localparam int unsigned ADDER_SEG   = 32;

    // Number of SEG-bit segments (and therefore pipeline stages) in a WIDTH-bit word.
    function automatic int unsigned adder_nseg(input int unsigned width, input int unsigned seg);
        return width / seg;
    endfunction

endpackage

// File: rtl/adder_seg_stage.sv
// One registered SEG-bit slice of the segmented adder.
// Ports:
//   CLK, RST   clock, synchronous active-high reset
//   ce         clock enable; 0 holds s/co
//   a, b       segment operands (b already inverted for subtract)
//   ci         carry into this segment
//   s, co      registered segment sum and carry out
module adder_seg_stage #(
    parameter int unsigned SEG = 32
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           ce,
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co
);

    localparam int unsigned SW = SEG + 1;

    logic [SEG:0] total_c;

    assign total_c = SW'(a) + SW'(b) + SW'(ci);

    always_ff @(posedge CLK) begin
        if (RST) begin
            s  <= '0;
            co <= 1'b0;
        end else if (ce) begin
            s  <= total_c[SEG-1:0];
            co <= total_c[SEG];
        end
    end

endmodule

// File: rtl/adder_segmented_pipe.sv
// Pipelined add/subtract unit that splits a WIDTH-bit operation into
// NSEG = WIDTH/SEG registered segment additions, one per stage, with the
// carry rippling stage to stage. Upper operand segments are skewed forward
// and finished lower result segments are deskewed so a whole result exits
// together NSEG enabled cycles after it was accepted.
// Ports:
//   CLK, RST        clock, synchronous active-high reset (wins over ce)
//   ce              clock enable; 0 freezes every register including valids
//   in_valid        operands valid this cycle
//   a, b, cin, sub  operands, carry-in, 0 = a+b+cin, 1 = a-b-cin
//   out_valid       result valid
//   sum, cout, ovf  result, carry out of the MSB, signed overflow
module adder_segmented_pipe
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = ADDER_WIDTH,
    parameter int unsigned SEG   = ADDER_SEG
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ce,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NSEG = adder_nseg(WIDTH, SEG);

    // Subtract as a + ~b + ~cin.
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    assign b_eff = b ^ {WIDTH{sub}};
    assign c_eff = cin ^ sub;

    // Valid bit travels alongside its data.
    logic [NSEG-1:0] vld_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_q <= '0;
        end else if (ce) begin
            vld_q[0] <= in_valid;
            for (int i = 1; i < int'(NSEG); i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[NSEG-1];

    for (genvar k = 0; k < NSEG; k++) begin : g_stg
        logic [SEG-1:0]       a_in;
        logic [SEG-1:0]       b_in;
        logic                 c_in;
        logic [SEG-1:0]       s_q;
        logic                 c_q;
        // Result segments 0..k of the operation that just left this stage.
        logic [(k+1)*SEG-1:0] res;

        if (k == 0) begin : g_head
            assign a_in = a[SEG-1:0];
            assign b_in = b_eff[SEG-1:0];
            assign c_in = c_eff;
            assign res  = s_q;
        end else begin : g_body
            assign a_in = g_stg[k-1].g_fwd.a_up[SEG-1:0];
            assign b_in = g_stg[k-1].g_fwd.b_up[SEG-1:0];
            assign c_in = g_stg[k-1].c_q;
            assign res  = {s_q, g_stg[k-1].g_fwd.lo_q};
        end

        adder_seg_stage #(
            .SEG (SEG)
        ) u_stage (
            .CLK (CLK),
            .RST (RST),
            .ce  (ce),
            .a   (a_in),
            .b   (b_in),
            .ci  (c_in),
            .s   (s_q),
            .co  (c_q)
        );

        // Skew of still-unused operand segments and deskew of finished results.
        if (k < NSEG - 1) begin : g_fwd
            localparam int unsigned UW = (NSEG - 1 - k) * SEG;

            logic [UW-1:0]        a_up;
            logic [UW-1:0]        b_up;
            logic [UW-1:0]        a_nx;
            logic [UW-1:0]        b_nx;
            logic [(k+1)*SEG-1:0] lo_q;

            if (k == 0) begin : g_src_in
                assign a_nx = a[WIDTH-1:SEG];
                assign b_nx = b_eff[WIDTH-1:SEG];
            end else begin : g_src_prev
                assign a_nx = g_stg[k-1].g_fwd.a_up[UW+SEG-1:SEG];
                assign b_nx = g_stg[k-1].g_fwd.b_up[UW+SEG-1:SEG];
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    a_up <= '0;
                    b_up <= '0;
                    lo_q <= '0;
                end else if (ce) begin
                    a_up <= a_nx;
                    b_up <= b_nx;
                    lo_q <= res;
                end
            end
        end
    end

    assign sum  = g_stg[NSEG-1].res;
    assign cout = g_stg[NSEG-1].c_q;

    // Overflow is resolved alongside the top segment so it exits with sum.
    logic top_a_sign;
    logic top_b_sign;
    logic top_s_sign;
    logic ovf_q;

    assign top_a_sign = g_stg[NSEG-1].a_in[SEG-1];
    assign top_b_sign = g_stg[NSEG-1].b_in[SEG-1];
    assign top_s_sign = 1'(SEG'(g_stg[NSEG-1].a_in + g_stg[NSEG-1].b_in
                                + SEG'(g_stg[NSEG-1].c_in)) >> (SEG - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf_q <= 1'b0;
        end else if (ce) begin
            ovf_q <= (top_a_sign == top_b_sign) && (top_s_sign != top_a_sign);
        end
    end

    assign ovf = ovf_q;

endmodule

// File: tb/tb_adder_segmented_pipe.sv
// Bench for adder_segmented_pipe: three instances (64/32, 96/32, 64/64)
// share control; expectations are queued at drive time with the enabled-edge
// count at which they must appear, and popped/compared every clock.
module tb_adder_segmented_pipe;

    typedef struct {
        logic [95:0] sum;
        logic        cout;
        logic        ovf;
        int          due;
    } exp_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        sub;
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ce;
    logic        in_valid;
    logic        cin;
    logic        sub;
    logic [63:0] a;
    logic [63:0] b;
    logic [95:0] a1;
    logic [95:0] b1;

    logic        ov0, co0, of0;
    logic        ov1, co1, of1;
    logic        ov2, co2, of2;
    logic [63:0] s0;
    logic [95:0] s1;
    logic [63:0] s2;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int   en_cnt = 0;
    int   n_chk  = 0;
    int   n_pass = 0;
    logic last_v[3];
    exp_t last_e[3];

    always #5 CLK = ~CLK;

    adder_segmented_pipe u_dut0 (
        .CLK(CLK), .RST(RST), .ce(ce), .in_valid(in_valid),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(ov0), .sum(s0), .cout(co0), .ovf(of0)
    );

    adder_segmented_pipe #(.WIDTH(96), .SEG(32)) u_dut1 (
        .CLK(CLK), .RST(RST), .ce(ce), .in_valid(in_valid),
        .a(a1), .b(b1), .cin(cin), .sub(sub),
        .out_valid(ov1), .sum(s1), .cout(co1), .ovf(of1)
    );

    adder_segmented_pipe #(.WIDTH(64), .SEG(64)) u_dut2 (
        .CLK(CLK), .RST(RST), .ce(ce), .in_valid(in_valid),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(ov2), .sum(s2), .cout(co2), .ovf(of2)
    );

    // Plain arithmetic reference for a w-bit add/subtract.
    function automatic exp_t model(input int unsigned w, input logic [95:0] x,
                                   input logic [95:0] y, input logic c, input logic s);
        logic [96:0] t;
        logic [95:0] m;
        logic [95:0] ye;
        exp_t        e;
        m      = (w == 96) ? {96{1'b1}} : {32'h0, {64{1'b1}}};
        ye     = (s ? ~y : y) & m;
        t      = {1'b0, x & m} + {1'b0, ye} + 97'(c ^ s);
        e.sum  = t[95:0] & m;
        e.cout = t[w];
        e.ovf  = (x[w-1] == ye[w-1]) && (e.sum[w-1] != x[w-1]);
        e.due  = 0;
        return e;
    endfunction

    function automatic exp_t mk64(input logic [63:0] s, input logic c, input logic o);
        exp_t e;
        e.sum  = 96'(s);
        e.cout = c;
        e.ovf  = o;
        e.due  = 0;
        return e;
    endfunction

    function automatic logic [95:0] rnd96();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string name, input logic [98:0] act, input logic [98:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    // Per-instance output check for one clock edge.
    task automatic mon(input int id, input logic r, input logic en, input logic ov,
                       input logic [95:0] s, input logic co, input logic of);
        exp_t  e;
        logic  have;
        string nm;
        nm   = $sformatf("dut%0d", id);
        have = 1'b0;
        if (r) begin
            check({nm, "_reset"}, {ov, co, of, s}, 99'd0);
            last_v[id] = 1'b0;
        end else if (!en) begin
            if (last_v[id])
                check({nm, "_hold"}, {ov, co, of, s},
                      {1'b1, last_e[id].cout, last_e[id].ovf, last_e[id].sum});
            else
                check({nm, "_hold_idle"}, 99'(ov), 99'd0);
        end else begin
            case (id)
                0: if (q0.size() > 0 && q0[0].due == en_cnt) begin e = q0.pop_front(); have = 1'b1; end
                1: if (q1.size() > 0 && q1[0].due == en_cnt) begin e = q1.pop_front(); have = 1'b1; end
                default: if (q2.size() > 0 && q2[0].due == en_cnt) begin e = q2.pop_front(); have = 1'b1; end
            endcase
            if (have)
                check({nm, "_result"}, {ov, co, of, s}, {1'b1, e.cout, e.ovf, e.sum});
            else
                check({nm, "_idle"}, 99'(ov), 99'd0);
            last_v[id] = have;
            if (have) last_e[id] = e;
        end
    endtask

    always @(posedge CLK) begin : mon_blk
        logic r;
        logic en;
        r  = RST;
        en = ce;
        if (r) begin
            q0.delete();
            q1.delete();
            q2.delete();
        end else if (en) begin
            en_cnt++;
        end
        #1;
        mon(0, r, en, ov0, 96'(s0), co0, of0);
        mon(1, r, en, ov1, s1, co1, of1);
        mon(2, r, en, ov2, 96'(s2), co2, of2);
    end

    // Apply one cycle of stimulus; queue expectations for accepted operations.
    task automatic drive(input logic v, input logic e_en, input logic r,
                         input logic [63:0] x, input logic [63:0] y, input logic c, input logic s,
                         input logic [95:0] x1, input logic [95:0] y1, input exp_t e64);
        exp_t e;
        exp_t e1;
        @(negedge CLK);
        RST = r; ce = e_en; in_valid = v;
        a = x; b = y; cin = c; sub = s; a1 = x1; b1 = y1;
        if (v && e_en && !r) begin
            e = e64; e.due = en_cnt + 2; q0.push_back(e);
            e = e64; e.due = en_cnt + 1; q2.push_back(e);
            e1 = model(96, x1, y1, c, s); e1.due = en_cnt + 3; q1.push_back(e1);
        end
    endtask

    task automatic idle(input logic e_en, input logic r);
        drive(1'b0, e_en, r, 64'd0, 64'd0, 1'b0, 1'b0, 96'd0, 96'd0, mk64(64'd0, 1'b0, 1'b0));
    endtask

    task automatic op64(input logic [63:0] x, input logic [63:0] y, input logic c, input logic s);
        drive(1'b1, 1'b1, 1'b0, x, y, c, s, rnd96(), rnd96(), model(64, 96'(x), 96'(y), c, s));
    endtask

    initial begin
        vec_t        tbl[11];
        logic [63:0] x;
        logic [63:0] y;
        logic [95:0] x1;
        logic [95:0] y1;
        logic        c;
        logic        s;
        logic        v;
        logic        en;

        tbl[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0};
        tbl[1]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        tbl[2]  = '{64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        tbl[3]  = '{64'd10, 64'd3, 1'b1, 1'b1, 64'd6, 1'b1, 1'b0};
        tbl[4]  = '{64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
        tbl[5]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1};
        tbl[6]  = '{64'd0, 64'd0, 1'b1, 1'b0, 64'd1, 1'b0, 1'b0};
        tbl[7]  = '{64'd0, 64'd0, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0};
        tbl[8]  = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        tbl[9]  = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0,
                    64'h2222_2222_2222_2211, 1'b0, 1'b0};
        tbl[10] = '{64'h0000_0001_0000_0000, 64'd1, 1'b0, 1'b1, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0};

        RST = 1'b1; ce = 1'b1; in_valid = 1'b0; cin = 1'b0; sub = 1'b0;
        a = '0; b = '0; a1 = '0; b1 = '0;
        last_v = '{1'b0, 1'b0, 1'b0};

        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);

        // Directed vectors, issued back to back.
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, 1'b1, 1'b0, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, rnd96(), rnd96(),
                  mk64(tbl[i].sum, tbl[i].cout, tbl[i].ovf));
        end
        repeat (4) idle(1'b1, 1'b0);

        // Streaming carries across the segment boundary.
        for (int i = 0; i < 8; i++) begin
            x = {32'(i), 32'hFFFF_FFFF};
            drive(1'b1, 1'b1, 1'b0, x, 64'd1, 1'b0, 1'b0, rnd96(), rnd96(),
                  mk64({32'(i + 1), 32'h0}, 1'b0, 1'b0));
        end
        repeat (4) idle(1'b1, 1'b0);

        // Freeze mid-stream with in_valid held high, then resume.
        for (int i = 0; i < 4; i++) op64({$urandom, $urandom}, {$urandom, $urandom}, 1'(i), 1'(i >> 1));
        repeat (3) drive(1'b1, 1'b0, 1'b0, 64'hDEAD_BEEF, 64'h1, 1'b0, 1'b0, '1, '1, mk64(64'd0, 1'b0, 1'b0));
        for (int i = 0; i < 2; i++) op64({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b1);

        // Reset with operations in flight (ce high, in_valid high): nothing may emerge.
        drive(1'b1, 1'b1, 1'b1, 64'd1, 64'd1, 1'b0, 1'b0, '1, 96'd1, mk64(64'd0, 1'b0, 1'b0));
        repeat (5) idle(1'b1, 1'b0);
        op64(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        repeat (4) idle(1'b1, 1'b0);

        // Reset while frozen also discards the in-flight operation.
        op64(64'd100, 64'd23, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 64'd0, 64'd0, 1'b0, 1'b0, 96'd0, 96'd0, mk64(64'd0, 1'b0, 1'b0));
        repeat (5) idle(1'b1, 1'b0);

        // Random traffic with valid gaps, ce bubbles and all-ones corners.
        for (int i = 0; i < 10000; i++) begin
            x  = {$urandom, $urandom};
            y  = {$urandom, $urandom};
            x1 = rnd96();
            y1 = rnd96();
            case ($urandom_range(0, 7))
                0: begin x = '1; x1 = '1; end
                1: begin y = '1; y1 = '1; end
                2: begin x = 64'h7FFF_FFFF_FFFF_FFFF; x1 = {1'b0, {95{1'b1}}}; end
                default: ;
            endcase
            c  = 1'($urandom_range(0, 1));
            s  = 1'($urandom_range(0, 1));
            v  = ($urandom_range(0, 7) != 0);
            en = ($urandom_range(0, 15) != 0);
            drive(v, en, 1'b0, x, y, c, s, x1, y1, model(64, 96'(x), 96'(y), c, s));
        end

        for (int i = 0; i < 20 && (q0.size() + q1.size() + q2.size()) != 0; i++) idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        check("drain", 99'(q0.size() + q1.size() + q2.size()), 99'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
